// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-computing frame decoder.
// Optional feature macro used elsewhere: SC_FRAME_DECODER_PROGRESSIVE_EN.
package sc_pkg;

  localparam int SC_TW_DEFAULT = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } sc_state_t;

  // Index of the highest set bit; 0 for a zero operand (callers guard zero).
  function automatic logic [31:0] floor_log2(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r = 32'(i);
    end
    return r;
  endfunction

  // Rescale a ones count taken over 'cycles' bits to a full-scale tw-bit
  // value: ones << (tw - floor(log2 cycles)), saturated at 2^tw - 1.
  function automatic logic [31:0] sc_rescale(input logic [31:0] ones,
                                             input logic [31:0] cycles,
                                             input int tw);
    logic [31:0] k;
    logic [31:0] shifted;
    logic [31:0] max_val;
    if (cycles == '0) return '0;
    k       = floor_log2(cycles);
    shifted = ones << (32'(tw) - k);
    max_val = (32'd1 << tw) - 32'd1;
    return (shifted > max_val) ? max_val : shifted;
  endfunction

endpackage

// File: rtl/sc_frame_decoder_if.sv
// Bitstream input, result handshake and status signals of the frame decoder.
interface sc_frame_decoder_if
  import sc_pkg::*;
#(
  parameter int TW = SC_TW_DEFAULT
);
  logic          start;
  logic          stop;
  logic          bit_valid;
  logic          bit_in;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_value;
  logic [TW:0]   out_cycles;
  logic          out_err;
  logic          est_valid;
  logic [TW-1:0] est_value;
  logic          busy;

  modport master (
    output start, stop, bit_valid, bit_in, out_ready,
    input  out_valid, out_value, out_cycles, out_err, est_valid, est_value, busy
  );

  modport slave (
    input  start, stop, bit_valid, bit_in, out_ready,
    output out_valid, out_value, out_cycles, out_err, est_valid, est_value, busy
  );
endinterface

// File: rtl/sc_rescaler.sv
// Combinational scaler: maps (ones, cycles) to a full-scale TW-bit value and
// flags whether cycles is a nonzero power of two.
module sc_rescaler
  import sc_pkg::*;
#(
  parameter int TW = SC_TW_DEFAULT
) (
  input  logic [TW:0]   ones,
  input  logic [TW:0]   cycles,
  output logic [TW-1:0] value,
  output logic          pow2
);

  localparam logic [TW:0] ONE = {{TW{1'b0}}, 1'b1};

  // Shift by the missing octaves of frame length, then saturate.
  always_comb begin
    value = TW'(sc_rescale(32'(ones), 32'(cycles), TW));
  end

  // Power of two: exactly one bit set; zero is not a power of two.
  always_comb begin
    pow2 = (cycles != '0) && ((cycles & (cycles - ONE)) == '0);
  end

endmodule

// File: rtl/sc_frame_decoder.sv
// Stochastic bitstream frame decoder: counts ones over a frame closed by
// 2^TW accepted bits or a stop request, rescales to full scale and presents
// the result on a valid/ready handshake.
// Optional macro SC_FRAME_DECODER_PROGRESSIVE_EN adds progressive estimates
// at every power-of-two bit count.
//
// state | meaning
// IDLE  | waiting for start; bits ignored
// ACCUM | counting accepted bits and ones (busy)
// HOLD  | result presented, waiting for out_ready
module sc_frame_decoder
  import sc_pkg::*;
#(
  parameter int TW = SC_TW_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  sc_frame_decoder_if.slave bus
);

  localparam logic [TW:0] FULL = {1'b1, {TW{1'b0}}};

  sc_state_t     state_q, state_d;
  logic [TW:0]   cyc_cnt, ones_cnt;
  logic [TW:0]   cyc_nxt, ones_nxt;
  logic          accept;
  logic          clr_cnt;
  logic          load_res;
  logic [TW-1:0] scaled;
  logic          pow2;
  logic [TW-1:0] out_value_q;
  logic [TW:0]   out_cycles_q;
  logic          out_err_q;

  // Counts as they stand after this cycle's bit (if one is accepted).
  always_comb begin
    accept   = (state_q == ACCUM) && bus.bit_valid;
    cyc_nxt  = cyc_cnt + {{TW{1'b0}}, accept};
    ones_nxt = ones_cnt + {{TW{1'b0}}, accept & bus.bit_in};
  end

  // One scaler serves both the final result and the progressive estimate,
  // since both are taken on the post-bit counts.
  sc_rescaler #(.TW(TW)) u_rescaler (
    .ones   (ones_nxt),
    .cycles (cyc_nxt),
    .value  (scaled),
    .pow2   (pow2)
  );

  // Next-state logic and datapath strobes.
  always_comb begin
    state_d  = state_q;
    clr_cnt  = 1'b0;
    load_res = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ACCUM;
          clr_cnt = 1'b1;
        end
      end
      ACCUM: begin
        if (bus.stop || (accept && (cyc_nxt == FULL))) begin
          state_d  = HOLD;
          load_res = 1'b1;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          if (bus.start) begin
            state_d = ACCUM;
            clr_cnt = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Frame counters: cleared on frame open, advanced on accepted bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt  <= '0;
      ones_cnt <= '0;
    end else if (clr_cnt) begin
      cyc_cnt  <= '0;
      ones_cnt <= '0;
    end else if (accept) begin
      cyc_cnt  <= cyc_nxt;
      ones_cnt <= ones_nxt;
    end
  end

  // Result registers: loaded on entry to HOLD, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_value_q  <= '0;
      out_cycles_q <= '0;
      out_err_q    <= 1'b0;
    end else if (load_res) begin
      out_value_q  <= scaled;
      out_cycles_q <= cyc_nxt;
      out_err_q    <= ~pow2;
    end
  end

  assign bus.out_valid  = (state_q == HOLD);
  assign bus.busy       = (state_q == ACCUM);
  assign bus.out_value  = out_value_q;
  assign bus.out_cycles = out_cycles_q;
  assign bus.out_err    = out_err_q;

`ifdef SC_FRAME_DECODER_PROGRESSIVE_EN
  logic          est_fire;
  logic          est_valid_q;
  logic [TW-1:0] est_value_q;

  assign est_fire = accept && pow2;

  // Estimate strobe one cycle after a power-of-two count; value cleared at frame open.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      est_valid_q <= 1'b0;
      est_value_q <= '0;
    end else begin
      est_valid_q <= est_fire;
      if (clr_cnt)       est_value_q <= '0;
      else if (est_fire) est_value_q <= scaled;
    end
  end

  assign bus.est_valid = est_valid_q;
  assign bus.est_value = est_value_q;
`else
  assign bus.est_valid = 1'b0;
  assign bus.est_value = '0;
`endif

endmodule

// File: tb/tb_sc_frame_decoder.sv
// Self-checking bench for sc_frame_decoder at TW=4 with a frame-level model.
module tb_sc_frame_decoder;
  localparam int TW   = 4;
  localparam int FULL = 1 << TW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sc_frame_decoder_if #(.TW(TW)) bus ();
  sc_frame_decoder #(.TW(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int est_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected value from the definition: ones / 2^K scaled to 2^TW, saturated.
  function automatic int exp_scale(input int ones, input int c);
    int p;
    int v;
    if (c == 0) return 0;
    p = 1;
    while (p * 2 <= c) p = p * 2;
    v = (ones * FULL) / p;
    return (v > FULL - 1) ? FULL - 1 : v;
  endfunction

  function automatic bit is_pow2(input int c);
    return $countones(c) == 1;
  endfunction

  // Frame-level model: 0 waiting, 1 collecting, 2 presenting.
  int m_mode = 0, m_c = 0, m_ones = 0;
  int m_value = 0, m_cycles = 0, m_err = 0;
  int m_est_valid = 0, m_est_value = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_c = 0; m_ones = 0;
      m_value = 0; m_cycles = 0; m_err = 0;
      m_est_valid = 0; m_est_value = 0;
    end else begin
      m_est_valid = 0;
      case (m_mode)
        0: if (bus.start) begin
          m_mode = 1; m_c = 0; m_ones = 0; m_est_value = 0;
        end
        1: begin
          if (bus.bit_valid) begin
            m_c++;
            m_ones += int'(bus.bit_in);
`ifdef SC_FRAME_DECODER_PROGRESSIVE_EN
            if (is_pow2(m_c)) begin
              m_est_valid = 1;
              m_est_value = exp_scale(m_ones, m_c);
            end
`endif
          end
          if (bus.stop || m_c == FULL) begin
            m_mode = 2;
            m_value = exp_scale(m_ones, m_c);
            m_cycles = m_c;
            m_err = is_pow2(m_c) ? 0 : 1;
          end
        end
        default: if (bus.out_ready) begin
          if (bus.start) begin
            m_mode = 1; m_c = 0; m_ones = 0; m_est_value = 0;
          end else begin
            m_mode = 0;
          end
        end
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("out_valid", 32'(bus.out_valid), 32'(m_mode == 2));
    chk("busy", 32'(bus.busy), 32'(m_mode == 1));
    chk("out_value", 32'(bus.out_value), 32'(m_value));
    chk("out_cycles", 32'(bus.out_cycles), 32'(m_cycles));
    chk("out_err", 32'(bus.out_err), 32'(m_err));
    chk("est_valid", 32'(bus.est_valid), 32'(m_est_valid));
    chk("est_value", 32'(bus.est_value), 32'(m_est_value));
    if (bus.est_valid === 1'b1) est_log.push_back(int'(bus.est_value));
  end

  task automatic cyc(input bit bv, input bit bi, input bit st, input bit sr, input bit rdy);
    @(negedge clk);
    bus.bit_valid = bv;
    bus.bit_in    = bi;
    bus.stop      = st;
    bus.start     = sr;
    bus.out_ready = rdy;
  endtask

  // Open a frame (unless already opened by a handshake) and stream n bits.
  task automatic run_frame(input bit do_start, input int n, input logic [15:0] pat,
                           input bit do_stop, input bit gaps);
    if (do_start) cyc(0, 0, 0, 1, 0);
    if (n == 0) begin
      if (do_stop) cyc(0, 0, 1, 0, 0);
    end
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 2 == 1)) cyc(0, 0, 0, 0, 0);
      cyc(1, pat[i], do_stop && (i == n - 1), 0, 0);
    end
  endtask

  task automatic expect_result(input string tag, input int v, input int c, input int e);
    int waited;
    waited = 0;
    cyc(0, 0, 0, 0, 0);
    chk({tag, " latency"}, 32'(bus.out_valid), 32'd1);
    while (bus.out_valid !== 1'b1 && waited < 10) begin
      cyc(0, 0, 0, 0, 0);
      waited++;
    end
    chk({tag, " value"}, 32'(bus.out_value), 32'(v));
    chk({tag, " cycles"}, 32'(bus.out_cycles), 32'(c));
    chk({tag, " err"}, 32'(bus.out_err), 32'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 0; bus.stop = 0; bus.bit_valid = 0; bus.bit_in = 0; bus.out_ready = 0;
    repeat (3) @(negedge clk);
    chk("reset valid", 32'(bus.out_valid), 0);
    chk("reset busy", 32'(bus.busy), 0);
    chk("reset value", 32'(bus.out_value), 0);
    chk("reset cycles", 32'(bus.out_cycles), 0);
    rst = 1'b0;

    // Full frame, 6 ones of 16.
    run_frame(1, 16, 16'h003F, 0, 0);
    expect_result("full", 6, 16, 0);
    cyc(0, 0, 0, 0, 1);

    // Early stop at 8 bits, 5 ones; then with gaps.
    run_frame(1, 8, 16'h001F, 1, 0);
    expect_result("stop8", 10, 8, 0);
    cyc(0, 0, 0, 0, 1);
    run_frame(1, 8, 16'h001F, 1, 1);
    expect_result("stop8gap", 10, 8, 0);
    cyc(0, 0, 0, 0, 1);

    // Non-power-of-two and zero-length frames.
    run_frame(1, 6, 16'h0007, 1, 0);
    expect_result("len6", 12, 6, 1);
    cyc(0, 0, 0, 0, 1);
    run_frame(1, 0, 16'h0000, 1, 0);
    expect_result("len0", 0, 0, 1);
    cyc(0, 0, 0, 0, 1);

    // Saturation, then backpressure with bits/start ignored while held.
    run_frame(1, 16, 16'hFFFF, 0, 0);
    expect_result("sat", 15, 16, 0);
    repeat (5) cyc(1, 1, 0, 1, 0);
    chk("bp valid", 32'(bus.out_valid), 1);
    chk("bp value", 32'(bus.out_value), 15);
    chk("bp cycles", 32'(bus.out_cycles), 16);
    // Handshake with start: next frame counts from zero.
    cyc(0, 0, 0, 1, 1);
    run_frame(0, 4, 16'h0002, 1, 0);
    expect_result("b2b", 4, 4, 0);
    cyc(0, 0, 0, 0, 1);

    // Reset mid-frame.
    run_frame(1, 5, 16'h001F, 0, 0);
    cyc(0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("midrst valid", 32'(bus.out_valid), 0);
    chk("midrst busy", 32'(bus.busy), 0);
    chk("midrst value", 32'(bus.out_value), 0);
    chk("midrst cycles", 32'(bus.out_cycles), 0);
    chk("midrst err", 32'(bus.out_err), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    run_frame(1, 2, 16'h0001, 1, 0);
    expect_result("afterrst", 8, 2, 0);
    cyc(0, 0, 0, 0, 1);

    // Progressive estimate stream 1,0,1,1,0.
    est_log.delete();
    run_frame(1, 5, 16'h000D, 1, 0);
    expect_result("prog", 12, 5, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
`ifdef SC_FRAME_DECODER_PROGRESSIVE_EN
    chk("est count", 32'(est_log.size()), 3);
    if (est_log.size() == 3) begin
      chk("est at 1", 32'(est_log[0]), 15);
      chk("est at 2", 32'(est_log[1]), 8);
      chk("est at 4", 32'(est_log[2]), 12);
    end
`else
    chk("est absent", 32'(est_log.size()), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
